mkio_channel_mux: RTL and testbench

Parametrised N-channel redundancy front end for the MKIO remote terminal. It sits between the line transceivers and the single receiver/transmitter pair. It replaces the fixed two-channel OR-merge with per-channel synchronisation, selection of the first active channel, and lock-on until bus idle. Replies are routed to the locked channel only, with a programmable strobe/inhibit hold and per-channel saturating parity-error counters.

---
 rtl/mkio_pkg.sv | 21 ++
 rtl/mkio_channel_mux_if.sv | 28 ++
 rtl/mkio_in_sync.sv | 35 +++
 rtl/mkio_channel_mux.sv | 188 ++++++++++++++++++
 tb/tb_mkio_channel_mux.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mkio_pkg.sv
// mkio_pkg: shared types and constants for the MKIO channel redundancy front end.
//   mux_state_e : front-end state (idle / locked receive / transmit / post-transmit hold)
//   ERR_W       : width of one per-channel parity-error counter
//   ch_idx_w()  : width needed to index a given number of channels
package mkio_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLock,
    StTx,
    StHold
  } mux_state_e;

  localparam int unsigned ERR_W = 8;

  // Never returns 0 so a one-channel build still has a legal index vector.
  function automatic int unsigned ch_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mkio_channel_mux_if.sv
// mkio_channel_mux_if: line-transceiver side of the channel mux, one bit per channel.
//   di1, di0   : receive lines from the transceivers
//   do1, do0   : transmit lines to the transceivers
//   rx_strob   : receiver strobe, 1 = receive enabled
//   tx_inhibit : transmitter inhibit, 1 = inhibited
// Modports: slave = the mux, master = the transceivers (or a bench standing in for them).
interface mkio_channel_mux_if #(
  parameter int unsigned CHANNELS = 2
);

  logic [CHANNELS-1:0] di1;
  logic [CHANNELS-1:0] di0;
  logic [CHANNELS-1:0] do1;
  logic [CHANNELS-1:0] do0;
  logic [CHANNELS-1:0] rx_strob;
  logic [CHANNELS-1:0] tx_inhibit;

  modport slave (
    input  di1, di0,
    output do1, do0, rx_strob, tx_inhibit
  );

  modport master (
    output di1, di0,
    input  do1, do0, rx_strob, tx_inhibit
  );

endinterface

// File: rtl/mkio_in_sync.sv
// mkio_in_sync: synchroniser for one bus channel's receive pair.
//   clk, reset : system clock, asynchronous active-low reset
//   d1, d0     : raw receive lines of the channel
//   q1, q0     : synchronised receive lines
//   act        : channel activity (q1 | q0)
module mkio_in_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d1,
  input  logic d0,
  output logic q1,
  output logic q0,
  output logic act
);

  logic [SYNC_STAGES-1:0] s1_q;
  logic [SYNC_STAGES-1:0] s0_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q <= '0;
      s0_q <= '0;
    end else begin
      s1_q <= {s1_q[SYNC_STAGES-2:0], d1};
      s0_q <= {s0_q[SYNC_STAGES-2:0], d0};
    end
  end

  assign q1  = s1_q[SYNC_STAGES-1];
  assign q0  = s0_q[SYNC_STAGES-1];
  assign act = q1 | q0;

endmodule

// File: rtl/mkio_channel_mux.sv
// mkio_channel_mux: N-channel redundancy front end for the MKIO remote terminal.
// Locks onto the lowest-index active enabled channel, holds it until the bus goes idle,
// routes replies to the locked channel only and counts parity errors per channel.
//   clk, reset          : system clock, asynchronous active-low reset
//   line (slave)        : per-channel di1/di0 in, do1/do0/rx_strob/tx_inhibit out
//   ch_mask             : 1 = channel may be selected
//   rx_di1, rx_di0      : selected receive lines to the receiver
//   tx_do1, tx_do0      : transmitter Manchester output
//   tx_busy             : transmitter busy
//   rx_done, parity_error : receiver word-complete pulse and its error flag
//   err_clr             : clear all error counters
//   active_ch, locked   : current/last locked channel, 1 when not idle
//   err_cnt             : saturating error counters, channel i at [8i+7:8i]
module mkio_channel_mux
  import mkio_pkg::*;
#(
  parameter int unsigned CHANNELS    = 2,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned IDLE_CYCLES = 64,
  parameter int unsigned HOLD_CYCLES = 5
) (
  input  logic                           clk,
  input  logic                           reset,
  mkio_channel_mux_if.slave              line,
  input  logic [CHANNELS-1:0]            ch_mask,
  output logic                           rx_di1,
  output logic                           rx_di0,
  input  logic                           tx_do1,
  input  logic                           tx_do0,
  input  logic                           tx_busy,
  input  logic                           rx_done,
  input  logic                           parity_error,
  input  logic                           err_clr,
  output logic [ch_idx_w(CHANNELS)-1:0]  active_ch,
  output logic                           locked,
  output logic [ERR_W*CHANNELS-1:0]      err_cnt
);

  localparam int unsigned CH_W   = ch_idx_w(CHANNELS);
  localparam int unsigned IDLE_W = $clog2(IDLE_CYCLES + 1);
  localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);

  logic [CHANNELS-1:0] s1, s0, act;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_sync
    mkio_in_sync #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
      .clk  (clk),
      .reset(reset),
      .d1   (line.di1[i]),
      .d0   (line.di0[i]),
      .q1   (s1[i]),
      .q0   (s0[i]),
      .act  (act[i])
    );
  end

  mux_state_e          state_q, state_d;
  logic [CH_W-1:0]     active_q, active_d;
  logic [IDLE_W-1:0]   idle_cnt_q, idle_cnt_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic                rx_di1_q, rx_di0_q;
  logic [CHANNELS-1:0] do1_q, do0_q, rx_strob_q, tx_inhibit_q;
  logic                cand_valid;
  logic [CH_W-1:0]     cand_ch;
  logic                tx_mode, rx_pass, err_inc;
  logic [CHANNELS-1:0] sel_q, sel_d;

  // Lowest-index active and enabled channel; scanning downwards lets the lowest win.
  always_comb begin
    cand_valid = 1'b0;
    cand_ch    = '0;
    for (int i = int'(CHANNELS) - 1; i >= 0; i--) begin
      if (act[i] && ch_mask[i]) begin
        cand_valid = 1'b1;
        cand_ch    = CH_W'(i);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    active_d   = active_q;
    idle_cnt_d = idle_cnt_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      StIdle: begin
        if (cand_valid) begin
          state_d    = StLock;
          active_d   = cand_ch;
          idle_cnt_d = '0;
        end else if (tx_busy) begin
          state_d = StTx;
        end
      end
      StLock: begin
        if (!ch_mask[active_q]) begin
          state_d = StIdle;
        end else if (tx_busy) begin
          state_d = StTx;
        end else if (act[active_q]) begin
          idle_cnt_d = '0;
        end else if (idle_cnt_q == IDLE_W'(IDLE_CYCLES - 1)) begin
          state_d = StIdle;
        end else begin
          idle_cnt_d = idle_cnt_q + IDLE_W'(1);
        end
      end
      StTx: begin
        if (!tx_busy) begin
          state_d    = StHold;
          hold_cnt_d = HOLD_W'(HOLD_CYCLES);
        end
      end
      StHold: begin
        if (tx_busy) begin
          state_d = StTx;
        end else if (hold_cnt_q <= HOLD_W'(1)) begin
          state_d = StIdle;
        end else begin
          hold_cnt_d = hold_cnt_q - HOLD_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Strobe/inhibit follow the next state so they switch on the edge that sees tx_busy.
  assign tx_mode = (state_d == StTx) || (state_d == StHold);
  // Receive path is only open while staying in LOCK; the first lock edge still shows 0.
  assign rx_pass = (state_q == StLock) && (state_d == StLock);
  assign sel_q   = CHANNELS'(1) << active_q;
  assign sel_d   = CHANNELS'(1) << active_d;
  assign err_inc = rx_done && parity_error && (state_q == StLock);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      active_q     <= '0;
      idle_cnt_q   <= '0;
      hold_cnt_q   <= '0;
      rx_di1_q     <= 1'b0;
      rx_di0_q     <= 1'b0;
      do1_q        <= '0;
      do0_q        <= '0;
      rx_strob_q   <= '1;
      tx_inhibit_q <= '1;
    end else begin
      state_q      <= state_d;
      active_q     <= active_d;
      idle_cnt_q   <= idle_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      rx_di1_q     <= rx_pass & s1[active_q];
      rx_di0_q     <= rx_pass & s0[active_q];
      do1_q        <= (state_q == StTx) ? (sel_q & {CHANNELS{tx_do1}}) : '0;
      do0_q        <= (state_q == StTx) ? (sel_q & {CHANNELS{tx_do0}}) : '0;
      rx_strob_q   <= tx_mode ? '0 : ch_mask;
      tx_inhibit_q <= tx_mode ? ~sel_d : '1;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_err
    logic [ERR_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        cnt_q <= '0;
      end else if (err_clr) begin
        cnt_q <= '0;
      end else if (err_inc && (active_q == CH_W'(i)) && (cnt_q != '1)) begin
        cnt_q <= cnt_q + ERR_W'(1);
      end
    end

    assign err_cnt[ERR_W*i +: ERR_W] = cnt_q;
  end

  assign line.do1        = do1_q;
  assign line.do0        = do0_q;
  assign line.rx_strob   = rx_strob_q;
  assign line.tx_inhibit = tx_inhibit_q;
  assign rx_di1          = rx_di1_q;
  assign rx_di0          = rx_di0_q;
  assign active_ch       = active_q;
  assign locked          = (state_q != StIdle);

endmodule

// File: tb/tb_mkio_channel_mux.sv
// Bench for mkio_channel_mux with three channels, 2-stage sync, 64 idle / 5 hold cycles.
module tb_mkio_channel_mux;
  import mkio_pkg::*;

  localparam int unsigned CH = 3;
  localparam int unsigned HB = 2;  // clk cycles per Manchester half-bit

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [CH-1:0] ch_mask;
  logic          rx_di1, rx_di0;
  logic          tx_do1, tx_do0, tx_busy;
  logic          rx_done, parity_error, err_clr;
  logic [1:0]    active_ch;
  logic          locked;
  logic [ERR_W*CH-1:0] err_cnt;

  mkio_channel_mux_if #(.CHANNELS(CH)) bus ();

  mkio_channel_mux #(
    .CHANNELS   (CH),
    .SYNC_STAGES(2),
    .IDLE_CYCLES(64),
    .HOLD_CYCLES(5)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .line        (bus),
    .ch_mask     (ch_mask),
    .rx_di1      (rx_di1),
    .rx_di0      (rx_di0),
    .tx_do1      (tx_do1),
    .tx_do0      (tx_do0),
    .tx_busy     (tx_busy),
    .rx_done     (rx_done),
    .parity_error(parity_error),
    .err_clr     (err_clr),
    .active_ch   (active_ch),
    .locked      (locked),
    .err_cnt     (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    int         kind;  // 0 = {rx_di1, rx_di0}, 1 = {do1, do0}
    logic [5:0] v;
  } sb_t;

  typedef struct {
    logic [CH-1:0] mask;
    logic [CH-1:0] act;
    logic          lck;
    logic [1:0]    ch;
  } vec_t;

  sb_t  sbq[$];
  vec_t vt[8];
  int   cyc  = 0;
  int   nvec = 0;
  int   nerr = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, got, exp);
    end
  endtask

  task automatic push(input int due, input int kind, input logic [5:0] v);
    sbq.push_back('{due: due, kind: kind, v: v});
  endtask

  // One clock: sample just after the edge and retire any scoreboard entries now due.
  task automatic tick();
    sb_t e;
    @(posedge clk);
    #1;
    cyc++;
    while (sbq.size() > 0 && sbq[0].due <= cyc) begin
      e = sbq.pop_front();
      if (e.kind == 0) chk("rx_di", 32'({rx_di1, rx_di0}), 32'(e.v));
      else             chk("do", 32'({bus.do1, bus.do0}), 32'(e.v));
    end
  endtask

  task automatic do_reset();
    reset        = 1'b0;
    bus.di1      = '0;
    bus.di0      = '0;
    tx_busy      = 1'b0;
    tx_do1       = 1'b0;
    tx_do0       = 1'b0;
    rx_done      = 1'b0;
    parity_error = 1'b0;
    err_clr      = 1'b0;
    sbq.delete();
    tick();
    tick();
    reset = 1'b1;
  endtask

  // Manchester word on every channel in chans; lock_ch carries word, the others ~word.
  task automatic run_word(input logic [CH-1:0] chans, input int lock_ch, input logic [15:0] word);
    logic [CH-1:0] d1, d0;
    logic [15:0]   w;
    logic          b;
    int            last;
    for (int i = 0; i < 32 * int'(HB); i++) begin
      d1 = '0;
      d0 = '0;
      for (int c = 0; c < int'(CH); c++) begin
        if (chans[c]) begin
          w     = (c == lock_ch) ? word : ~word;
          b     = w[15 - i / (2 * int'(HB))];
          d1[c] = (((i / int'(HB)) % 2) == 0) ? b : ~b;
          d0[c] = ~d1[c];
        end
      end
      bus.di1 = d1;
      bus.di0 = d0;
      push(cyc + 3, 0, (i == 0) ? 6'b0 : {4'b0, d1[lock_ch], d0[lock_ch]});
      tick();
    end
    last    = cyc - 1;
    bus.di1 = '0;
    bus.di0 = '0;
    while (cyc < last + 67) begin
      if (cyc + 3 <= last + 67) push(cyc + 3, 0, 6'b0);
      if (cyc == last + 66) begin
        chk("locked_before_release", 32'(locked), 32'(1));
        chk("word_active_ch", 32'(active_ch), 32'(lock_ch));
      end
      tick();
    end
    chk("released_after_idle", 32'(locked), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vt[0] = '{3'b111, 3'b101, 1'b1, 2'd0};
    vt[1] = '{3'b111, 3'b110, 1'b1, 2'd1};
    vt[2] = '{3'b110, 3'b101, 1'b1, 2'd2};
    vt[3] = '{3'b011, 3'b100, 1'b0, 2'd0};
    vt[4] = '{3'b111, 3'b100, 1'b1, 2'd2};
    vt[5] = '{3'b100, 3'b011, 1'b0, 2'd0};
    vt[6] = '{3'b101, 3'b111, 1'b1, 2'd0};
    vt[7] = '{3'b010, 3'b111, 1'b1, 2'd1};

    // Reset values: strobe is all ones regardless of ch_mask.
    ch_mask      = 3'b101;
    bus.di1      = '0;
    bus.di0      = '0;
    tx_busy      = 1'b0;
    tx_do1       = 1'b0;
    tx_do0       = 1'b0;
    rx_done      = 1'b0;
    parity_error = 1'b0;
    err_clr      = 1'b0;
    #1 reset = 1'b0;
    #1;
    chk("rst_rx_strob", 32'(bus.rx_strob), 32'(3'b111));
    chk("rst_tx_inhibit", 32'(bus.tx_inhibit), 32'(3'b111));
    chk("rst_do", 32'({bus.do1, bus.do0}), 32'(0));
    chk("rst_rx_di", 32'({rx_di1, rx_di0}), 32'(0));
    chk("rst_locked", 32'(locked), 32'(0));
    chk("rst_active_ch", 32'(active_ch), 32'(0));
    chk("rst_err_cnt", 32'(err_cnt), 32'(0));

    // Lock selection table.
    for (int i = 0; i < 8; i++) begin
      do_reset();
      ch_mask = vt[i].mask;
      bus.di1 = vt[i].act;
      tick();
      tick();
      tick();
      chk("tbl_locked", 32'(locked), 32'(vt[i].lck));
      chk("tbl_active_ch", 32'(active_ch), 32'(vt[i].ch));
      chk("tbl_rx_strob", 32'(bus.rx_strob), 32'(vt[i].mask));
      chk("tbl_tx_inhibit", 32'(bus.tx_inhibit), 32'(3'b111));
      tick();
      chk("tbl_rx_di", 32'({rx_di1, rx_di0}), vt[i].lck ? 32'(2'b10) : 32'(0));
    end

    // Word on channel 1 alone, then channels 0 and 2 together.
    do_reset();
    ch_mask = 3'b111;
    run_word(3'b010, 1, 16'hB38D);
    do_reset();
    ch_mask = 3'b111;
    run_word(3'b101, 0, 16'h6A5C);

    // Transmit on channel 1 with hold, including a re-rise during HOLD.
    do_reset();
    ch_mask = 3'b111;
    bus.di1 = 3'b010;
    repeat (6) tick();
    chk("tx_pre_locked", 32'(locked), 32'(1));
    chk("tx_pre_active", 32'(active_ch), 32'(1));
    bus.di1 = '0;
    tx_busy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tx_do1 = 1'($urandom_range(0, 1));
      tx_do0 = ~tx_do1;
      push(cyc + 1, 1, (i == 0) ? 6'b0 : {1'b0, tx_do1, 1'b0, 1'b0, tx_do0, 1'b0});
      tick();
      chk("tx_rx_strob", 32'(bus.rx_strob), 32'(3'b000));
      chk("tx_inhibit", 32'(bus.tx_inhibit), 32'(3'b101));
      chk("tx_rx_di", 32'({rx_di1, rx_di0}), 32'(0));
    end
    tx_busy = 1'b0;
    tx_do1  = 1'b0;
    tx_do0  = 1'b0;
    push(cyc + 1, 1, 6'b0);
    tick();
    tick();
    tx_busy = 1'b1;
    tick();
    tick();
    chk("rerise_locked", 32'(locked), 32'(1));
    chk("rerise_rx_strob", 32'(bus.rx_strob), 32'(3'b000));
    tx_busy = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("hold_rx_strob", 32'(bus.rx_strob), 32'(3'b000));
      chk("hold_inhibit", 32'(bus.tx_inhibit), 32'(3'b101));
      chk("hold_locked", 32'(locked), 32'(1));
    end
    tick();
    chk("release_rx_strob", 32'(bus.rx_strob), 32'(3'b111));
    chk("release_inhibit", 32'(bus.tx_inhibit), 32'(3'b111));
    chk("release_locked", 32'(locked), 32'(0));
    chk("release_do", 32'({bus.do1, bus.do0}), 32'(0));

    // Parity-error counter saturation and clear priority on channel 0.
    do_reset();
    ch_mask = 3'b111;
    bus.di1 = 3'b001;
    repeat (4) tick();
    chk("err_locked", 32'(locked), 32'(1));
    rx_done      = 1'b1;
    parity_error = 1'b1;
    repeat (100) tick();
    chk("err_100", 32'(err_cnt), 32'(100));
    parity_error = 1'b0;
    repeat (10) tick();
    chk("err_no_parity", 32'(err_cnt), 32'(100));
    parity_error = 1'b1;
    repeat (200) tick();
    chk("err_saturate", 32'(err_cnt), 32'(24'h0000FF));
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("err_clear_wins", 32'(err_cnt), 32'(0));
    tick();
    chk("err_after_clear", 32'(err_cnt), 32'(1));
    rx_done      = 1'b0;
    parity_error = 1'b0;

    // Mask drop while locked on channel 1.
    do_reset();
    ch_mask = 3'b111;
    bus.di1 = 3'b010;
    repeat (4) tick();
    chk("mask_locked", 32'(locked), 32'(1));
    chk("mask_rx_di", 32'({rx_di1, rx_di0}), 32'(2'b10));
    ch_mask = 3'b101;
    tick();
    chk("mask_drop_idle", 32'(locked), 32'(0));
    chk("mask_drop_strob", 32'(bus.rx_strob), 32'(3'b101));
    repeat (10) tick();
    chk("mask_ignored", 32'(locked), 32'(0));
    chk("mask_ignored_rx_di", 32'({rx_di1, rx_di0}), 32'(0));

    // Asynchronous reset in the middle of a transmission.
    do_reset();
    ch_mask = 3'b111;
    bus.di1 = 3'b010;
    repeat (4) tick();
    bus.di1 = '0;
    tx_busy = 1'b1;
    tx_do1  = 1'b1;
    tx_do0  = 1'b0;
    repeat (3) tick();
    chk("pre_rst_do", 32'({bus.do1, bus.do0}), 32'(6'b010000));
    chk("pre_rst_locked", 32'(locked), 32'(1));
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_do", 32'({bus.do1, bus.do0}), 32'(0));
    chk("mid_rst_rx_di", 32'({rx_di1, rx_di0}), 32'(0));
    chk("mid_rst_locked", 32'(locked), 32'(0));
    chk("mid_rst_inhibit", 32'(bus.tx_inhibit), 32'(3'b111));
    chk("mid_rst_strob", 32'(bus.rx_strob), 32'(3'b111));
    tx_busy = 1'b0;
    tx_do1  = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
